// File: rtl/noout_wb_arb.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone slave.
// One transaction in flight at a time; a watchdog errors out unanswered cycles.
module noout_wb_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [31:0]           m0_dat_i,
  output logic                  m0_stall_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [31:0]           m0_dat_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [31:0]           m1_dat_i,
  output logic                  m1_stall_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [31:0]           m1_dat_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [3:0]            s_sel_o,
  output logic [31:0]           s_dat_o,
  input  logic                  s_stall_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic [31:0]           s_dat_i
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state;
  logic                  owner;
  logic                  last;
  logic [WD_W-1:0]       wdog;

  logic [ADDR_WIDTH-1:0] adr_p0;
  logic [31:0]           dat_p0;
  logic [3:0]            sel_p0;
  logic                  we_p0;

  logic req0;
  logic req1;
  logic grant_vld;
  logic grant_sel;
  logic own_cyc;
  logic abort;
  logic resp;
  logic tmo;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;

  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (state == IDLE && (req0 || req1)) begin
      grant_vld = 1'b1;
      grant_sel = (req0 && req1) ? ~last : req1;
    end
  end

  // Stall is the only combinational output; forced high while reset is held.
  assign m0_stall_o = ~(rst_n_i & grant_vld & ~grant_sel);
  assign m1_stall_o = ~(rst_n_i & grant_vld &  grant_sel);

  always_comb begin
    abort = 1'b0;
    resp  = 1'b0;
    tmo   = 1'b0;
    if (state == ISSUE || state == WAIT) begin
      abort = ~own_cyc;
      resp  = own_cyc & (s_ack_i | s_err_i);
      tmo   = own_cyc & ~(s_ack_i | s_err_i) & (state == WAIT) & (wdog == WD_MAX);
    end
  end

  assign s_adr_o = adr_p0;
  assign s_dat_o = dat_p0;
  assign s_sel_o = sel_p0;
  assign s_we_o  = we_p0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      wdog     <= '0;
      adr_p0   <= '0;
      dat_p0   <= '0;
      sel_p0   <= '0;
      we_p0    <= 1'b0;
      s_cyc_o  <= 1'b0;
      s_stb_o  <= 1'b0;
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m0_dat_o <= '0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;
      m1_dat_o <= '0;
    end else begin
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;

      case (state)
        // Grant: capture the winner's request into the holding registers
        IDLE: begin
          if (grant_vld) begin
            owner   <= grant_sel;
            last    <= grant_sel;
            adr_p0  <= grant_sel ? m1_adr_i : m0_adr_i;
            dat_p0  <= grant_sel ? m1_dat_i : m0_dat_i;
            sel_p0  <= grant_sel ? m1_sel_i : m0_sel_i;
            we_p0   <= grant_sel ? m1_we_i  : m0_we_i;
            s_cyc_o <= 1'b1;
            s_stb_o <= 1'b1;
            state   <= ISSUE;
          end
        end
        // Issue: strobe held with stable fields until the slave accepts
        ISSUE: begin
          if (own_cyc && !resp && !s_stall_i) begin
            s_stb_o <= 1'b0;
            wdog    <= '0;
            state   <= WAIT;
          end
        end
        // Wait: watchdog runs until response, abort or expiry
        WAIT: begin
          if (own_cyc && !resp && !tmo) begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Error beats ack when the slave raises both.
      if (resp || tmo) begin
        if (owner) begin
          m1_ack_o <= resp & ~s_err_i;
          m1_err_o <= tmo | s_err_i;
          if (resp) m1_dat_o <= s_dat_i;
        end else begin
          m0_ack_o <= resp & ~s_err_i;
          m0_err_o <= tmo | s_err_i;
          if (resp) m0_dat_o <= s_dat_i;
        end
      end

      if (abort || resp || tmo) begin
        s_cyc_o <= 1'b0;
        s_stb_o <= 1'b0;
        state   <= IDLE;
      end
    end
  end

endmodule
